// File: rtl/bcd_key_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_key_sequencer_if
//  Description : Key handshake and adder-side bus of the BCD key sequencer.
//                The master side supplies key codes and the adder result; the
//                slave side (the sequencer) returns ready, operands and display.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_key_sequencer_if #(
    parameter int DIGITS = 2
);
    localparam int c_WIDTH = 4 * DIGITS;

    logic               key_valid;
    logic               key_ready;
    logic [3:0]         key_code;
    logic [c_WIDTH-1:0] sum;
    logic [c_WIDTH-1:0] a;
    logic [c_WIDTH-1:0] b;
    logic               sub;
    logic               op_valid;
    logic [c_WIDTH-1:0] display;

    // Keypad/adder environment
    modport master (
        output key_valid, key_code, sum,
        input  key_ready, a, b, sub, op_valid, display
    );

    // Key sequencer
    modport slave (
        input  key_valid, key_code, sum,
        output key_ready, a, b, sub, op_valid, display
    );
endinterface
`default_nettype wire

// File: rtl/bcd_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_key_sequencer
//  Description : Operand-entry stage for the BCD adder/subtractor. Collects
//                key codes into operands A and B, fires the adder for one
//                cycle on '=', captures the result as the new accumulator and
//                keeps a registered display value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_key_sequencer #(
    parameter int DIGITS    = 2,
    parameter bit REPEAT_EQ = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bcd_key_sequencer_if.slave bus_if
);

    localparam int              c_WIDTH    = 4 * DIGITS;
    localparam int              c_NDW      = $clog2(DIGITS + 1);
    localparam logic [c_NDW-1:0] c_NDIG_MAX = c_NDW'(DIGITS);

    localparam logic [3:0] c_KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] c_KEY_PLUS      = 4'd10;
    localparam logic [3:0] c_KEY_MINUS     = 4'd11;
    localparam logic [3:0] c_KEY_EQUALS    = 4'd12;
    localparam logic [3:0] c_KEY_CLEAR     = 4'd13;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_EXEC    = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_WIDTH-1:0] a_q, a_d;
    logic [c_WIDTH-1:0] b_q, b_d;
    logic [c_WIDTH-1:0] disp_q, disp_d;
    logic               sub_q, sub_d;
    logic [c_NDW-1:0]   ndig_q, ndig_d;

    logic               w_accept;
    logic               w_is_digit;
    logic               w_is_op;
    logic               w_is_eq;
    logic               w_room;
    logic               w_update;
    logic [c_WIDTH+3:0] w_a_cat;
    logic [c_WIDTH+3:0] w_b_cat;
    logic [c_WIDTH-1:0] w_a_shift;
    logic [c_WIDTH-1:0] w_b_shift;
    logic [c_WIDTH-1:0] w_digit_ext;

    // Keys are only taken outside the single adder-capture cycle
    assign bus_if.key_ready = (state_q != ST_EXEC);
    assign bus_if.op_valid  = (state_q == ST_EXEC);
    assign bus_if.a         = a_q;
    assign bus_if.b         = b_q;
    assign bus_if.sub       = sub_q;
    assign bus_if.display   = disp_q;

    assign w_accept    = bus_if.key_valid && (state_q != ST_EXEC);
    assign w_is_digit  = (bus_if.key_code <= c_KEY_DIGIT_MAX);
    assign w_is_op     = (bus_if.key_code == c_KEY_PLUS) || (bus_if.key_code == c_KEY_MINUS);
    assign w_is_eq     = (bus_if.key_code == c_KEY_EQUALS);
    assign w_room      = (ndig_q < c_NDIG_MAX);

    // Shift the new digit in at the least significant end; the oldest digit
    // can never fall off because entry stops once the operand is full.
    assign w_a_cat     = {a_q, bus_if.key_code};
    assign w_b_cat     = {b_q, bus_if.key_code};
    assign w_a_shift   = w_a_cat[c_WIDTH-1:0];
    assign w_b_shift   = w_b_cat[c_WIDTH-1:0];
    assign w_digit_ext = c_WIDTH'(bus_if.key_code);

    // Next-state and operand update for an accepted key or the capture cycle
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        ndig_d   = ndig_q;
        w_update = 1'b0;

        if (state_q == ST_EXEC) begin
            // Adder result becomes the accumulator for chaining
            w_update = 1'b1;
            a_d      = bus_if.sum;
            ndig_d   = '0;
            state_d  = ST_SHOW;
        end else if (w_accept) begin
            w_update = 1'b1;
            if (bus_if.key_code == c_KEY_CLEAR) begin
                state_d = ST_ENTER_A;
                a_d     = '0;
                b_d     = '0;
                sub_d   = 1'b0;
                ndig_d  = '0;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                a_d    = w_a_shift;
                                ndig_d = ndig_q + c_NDW'(1);
                            end
                        end else if (w_is_op) begin
                            sub_d   = (bus_if.key_code == c_KEY_MINUS);
                            b_d     = '0;
                            ndig_d  = '0;
                            state_d = ST_ENTER_B;
                        end
                    end
                    ST_ENTER_B: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                b_d    = w_b_shift;
                                ndig_d = ndig_q + c_NDW'(1);
                            end
                        end else if (w_is_op) begin
                            sub_d = (bus_if.key_code == c_KEY_MINUS);
                        end else if (w_is_eq) begin
                            state_d = ST_EXEC;
                        end
                    end
                    ST_SHOW: begin
                        if (w_is_digit) begin
                            // A fresh number replaces the shown result
                            a_d     = w_digit_ext;
                            ndig_d  = c_NDW'(1);
                            state_d = ST_ENTER_A;
                        end else if (w_is_op) begin
                            sub_d   = (bus_if.key_code == c_KEY_MINUS);
                            b_d     = '0;
                            ndig_d  = '0;
                            state_d = ST_ENTER_B;
                        end else if (w_is_eq && REPEAT_EQ) begin
                            state_d = ST_EXEC;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Display tracks the operand being edited; it holds its value while the
    // adder is being driven and picks up the result on the capture edge.
    always_comb begin
        disp_d = disp_q;
        if (w_update && (state_d != ST_EXEC)) begin
            if ((state_d == ST_ENTER_B) && (ndig_d != '0)) begin
                disp_d = b_d;
            end else begin
                disp_d = a_d;
            end
        end
    end

    // State and operand registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            ndig_q  <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            ndig_q  <= ndig_d;
            disp_q  <= disp_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_key_sequencer
//  Description : Self-checking bench for bcd_key_sequencer. Two instances
//                (repeat-equals on and off) share clock and reset; a
//                behavioural adder closes the loop and an integer-valued
//                calculator model predicts the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_key_sequencer;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Calculator model (values as plain integers 0..99)
    localparam int M_A    = 0;
    localparam int M_B    = 1;
    localparam int M_EXEC = 2;
    localparam int M_SHOW = 3;

    int m_a, m_b, m_nd, m_mode, m_disp;
    bit m_sub;

    bcd_key_sequencer_if #(.DIGITS(2)) bus1 ();
    bcd_key_sequencer_if #(.DIGITS(2)) bus0 ();

    bcd_key_sequencer #(.DIGITS(2), .REPEAT_EQ(1'b1)) u_dut_rep (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus1)
    );

    bcd_key_sequencer #(.DIGITS(2), .REPEAT_EQ(1'b0)) u_dut_norep (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus0)
    );

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [7:0] adder(input logic [7:0] x, input logic [7:0] y, input logic s);
        int r;
        if (s) r = (from_bcd(x) - from_bcd(y) + 100) % 100;
        else   r = (from_bcd(x) + from_bcd(y)) % 100;
        return bcd8(r);
    endfunction

    // Combinational adder closing the loop for both instances
    always_comb bus1.sum = adder(bus1.a, bus1.b, bus1.sub);
    always_comb bus0.sum = adder(bus0.a, bus0.b, bus0.sub);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_nd = 0; m_sub = 0; m_mode = M_A; m_disp = 0;
    endtask

    task automatic model_key(input int code);
        if (code == 13) begin
            model_reset();
        end else if (code <= 12) begin
            case (m_mode)
                M_A: begin
                    if (code <= 9) begin
                        if (m_nd < 2) begin m_a = (m_a * 10 + code) % 100; m_nd++; end
                        m_disp = m_a;
                    end else if (code != 12) begin
                        m_sub = (code == 11); m_b = 0; m_nd = 0; m_mode = M_B; m_disp = m_a;
                    end
                end
                M_B: begin
                    if (code <= 9) begin
                        if (m_nd < 2) begin m_b = (m_b * 10 + code) % 100; m_nd++; end
                        m_disp = m_b;
                    end else if (code == 12) begin
                        m_mode = M_EXEC;
                    end else begin
                        m_sub = (code == 11);
                    end
                end
                M_SHOW: begin
                    if (code <= 9) begin
                        m_a = code; m_nd = 1; m_mode = M_A; m_disp = m_a;
                    end else if (code == 12) begin
                        m_mode = M_EXEC;
                    end else begin
                        m_sub = (code == 11); m_b = 0; m_nd = 0; m_mode = M_B; m_disp = m_a;
                    end
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic model_exec();
        int r;
        r = m_sub ? (m_a - m_b + 100) % 100 : (m_a + m_b) % 100;
        m_a = r; m_disp = r; m_nd = 0; m_mode = M_SHOW;
    endtask

    // Present one key and hold it until accepted (bounded); returns #1 after
    // the accepting edge. Instance 1 keeps the model in step.
    task automatic press(input bit which, input int code);
        int   cnt;
        logic rdy;
        cnt = 0;
        @(negedge clk);
        if (which) begin bus1.key_valid = 1'b1; bus1.key_code = 4'(code); end
        else       begin bus0.key_valid = 1'b1; bus0.key_code = 4'(code); end
        rdy = which ? bus1.key_ready : bus0.key_ready;
        while (!rdy && cnt < 20) begin
            @(negedge clk);
            cnt++;
            rdy = which ? bus1.key_ready : bus0.key_ready;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL press_timeout: key %0d not accepted, key_ready=%b required 1", code, rdy);
        end
        @(posedge clk);
        #1;
        if (which) bus1.key_valid = 1'b0; else bus0.key_valid = 1'b0;
        if (which && rdy) model_key(code);
    endtask

    task automatic exec_step(input bit which);
        @(posedge clk);
        #1;
        if (which) model_exec();
    endtask

    task automatic press_seq(input bit which, input int k0, input int k1, input int k2,
                             input int k3, input int k4, input int k5, input int k6);
        int ks[7];
        ks = '{k0, k1, k2, k3, k4, k5, k6};
        for (int i = 0; i < 7; i++) if (ks[i] >= 0) press(which, ks[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid, bus1.key_ready,
             bus0.display, bus0.key_ready} !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_initial: a=%h b=%h sub=%b disp=%h opv=%b rdy=%b, required 00 00 0 00 0 1",
                     bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid, bus1.key_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        press_seq(1'b1, 5, 11, 3, -1, -1, -1, -1);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.display} !== {8'h05, 8'h03, 1'b1, 8'h03}) begin
            errors++;
            $display("FAIL reset_preload: a=%h b=%h sub=%b disp=%h, required 05 03 1 03",
                     bus1.a, bus1.b, bus1.sub, bus1.display);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid, bus1.key_ready}
                !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: a=%h b=%h sub=%b disp=%h opv=%b rdy=%b, required 00 00 0 00 0 1",
                     bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid, bus1.key_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_add();
        press_seq(1'b1, 13, 4, 2, 10, 1, 7, 12);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.op_valid, bus1.key_ready} !== {8'h42, 8'h17, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_exec: a=%h b=%h sub=%b opv=%b rdy=%b, required 42 17 0 1 0",
                     bus1.a, bus1.b, bus1.sub, bus1.op_valid, bus1.key_ready);
        end
        exec_step(1'b1);
        checks++;
        if ({bus1.a, bus1.display, bus1.op_valid} !== {8'h59, 8'h59, 1'b0}) begin
            errors++;
            $display("FAIL add_result: a=%h disp=%h opv=%b, required 59 59 0",
                     bus1.a, bus1.display, bus1.op_valid);
        end
    endtask

    task automatic test_sub_wrap();
        press_seq(1'b1, 13, 0, 3, 11, 0, 5, 12);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.op_valid} !== {8'h03, 8'h05, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_exec: a=%h b=%h sub=%b opv=%b, required 03 05 1 1",
                     bus1.a, bus1.b, bus1.sub, bus1.op_valid);
        end
        exec_step(1'b1);
        checks++;
        if (bus1.display !== 8'h98) begin
            errors++;
            $display("FAIL sub_result: disp=%h, required 98", bus1.display);
        end
        press_seq(1'b1, 10, 0, 2, 12, -1, -1, -1);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.op_valid} !== {8'h98, 8'h02, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL chain_exec: a=%h b=%h sub=%b opv=%b, required 98 02 0 1",
                     bus1.a, bus1.b, bus1.sub, bus1.op_valid);
        end
        exec_step(1'b1);
        checks++;
        if ({bus1.a, bus1.display} !== {8'h00, 8'h00}) begin
            errors++;
            $display("FAIL chain_wrap: a=%h disp=%h, required 00 00", bus1.a, bus1.display);
        end
    endtask

    task automatic test_overflow_clear();
        press_seq(1'b1, 13, 1, 2, 3, -1, -1, -1);
        checks++;
        if ({bus1.a, bus1.display} !== {8'h12, 8'h12}) begin
            errors++;
            $display("FAIL overflow: a=%h disp=%h, required 12 12", bus1.a, bus1.display);
        end
        press(1'b1, 13);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.display, bus1.key_ready} !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL clear: a=%h b=%h sub=%b disp=%h rdy=%b, required 00 00 0 00 1",
                     bus1.a, bus1.b, bus1.sub, bus1.display, bus1.key_ready);
        end
        // ENTER_A again: digits append from an empty operand
        press(1'b1, 6);
        checks++;
        if (bus1.a !== 8'h06) begin
            errors++;
            $display("FAIL clear_state: a=%h, required 06", bus1.a);
        end
    endtask

    task automatic test_repeat_eq();
        press_seq(1'b1, 13, 4, 2, 10, 1, 7, 12);
        exec_step(1'b1);
        press(1'b1, 12);
        checks++;
        if ({bus1.a, bus1.b, bus1.sub, bus1.op_valid} !== {8'h59, 8'h17, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL repeat_exec: a=%h b=%h sub=%b opv=%b, required 59 17 0 1",
                     bus1.a, bus1.b, bus1.sub, bus1.op_valid);
        end
        exec_step(1'b1);
        checks++;
        if (bus1.display !== 8'h76) begin
            errors++;
            $display("FAIL repeat_result: disp=%h, required 76", bus1.display);
        end
        press_seq(1'b0, 13, 4, 2, 10, 1, 7, 12);
        exec_step(1'b0);
        press(1'b0, 12);
        checks++;
        if ({bus0.op_valid, bus0.key_ready, bus0.display, bus0.a} !== {1'b0, 1'b1, 8'h59, 8'h59}) begin
            errors++;
            $display("FAIL norepeat: opv=%b rdy=%b disp=%h a=%h, required 0 1 59 59",
                     bus0.op_valid, bus0.key_ready, bus0.display, bus0.a);
        end
    endtask

    task automatic test_pending_exec();
        press_seq(1'b1, 13, 4, 2, 10, 1, 7, 12);
        @(negedge clk);
        bus1.key_valid = 1'b1;
        bus1.key_code  = 4'd8;
        checks++;
        if ({bus1.key_ready, bus1.op_valid} !== 2'b01) begin
            errors++;
            $display("FAIL pending_busy: rdy=%b opv=%b, required 0 1", bus1.key_ready, bus1.op_valid);
        end
        @(posedge clk);
        #1;
        model_exec();
        checks++;
        if ({bus1.op_valid, bus1.key_ready, bus1.a, bus1.display} !== {1'b0, 1'b1, 8'h59, 8'h59}) begin
            errors++;
            $display("FAIL pending_show: opv=%b rdy=%b a=%h disp=%h, required 0 1 59 59",
                     bus1.op_valid, bus1.key_ready, bus1.a, bus1.display);
        end
        @(posedge clk);
        #1;
        bus1.key_valid = 1'b0;
        model_key(8);
        checks++;
        if ({bus1.a, bus1.display} !== {8'h08, 8'h08}) begin
            errors++;
            $display("FAIL pending_accept: a=%h disp=%h, required 08 08", bus1.a, bus1.display);
        end
        press(1'b1, 3);
        checks++;
        if (bus1.a !== 8'h83) begin
            errors++;
            $display("FAIL pending_state: a=%h, required 83", bus1.a);
        end
    endtask

    task automatic test_reset_in_exec();
        press_seq(1'b1, 13, 1, 10, 1, 12, -1, -1);
        checks++;
        if (bus1.op_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstexec_pre: opv=%b, required 1", bus1.op_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus1.op_valid, bus1.key_ready, bus1.a, bus1.b, bus1.display} !== {1'b0, 1'b1, 8'h00, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rstexec_drop: opv=%b rdy=%b a=%h b=%h disp=%h, required 0 1 00 00 00",
                     bus1.op_valid, bus1.key_ready, bus1.a, bus1.b, bus1.display);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus1.op_valid, bus1.a, bus1.display} !== {1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rstexec_nocapture: opv=%b a=%h disp=%h, required 0 00 00",
                     bus1.op_valid, bus1.a, bus1.display);
        end
    endtask

    task automatic test_random();
        int code;
        press(1'b1, 13);
        for (int i = 0; i < 300; i++) begin
            code = int'($urandom_range(0, 15));
            press(1'b1, code);
            checks++;
            if ({bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid}
                    !== {bcd8(m_a), bcd8(m_b), m_sub, bcd8(m_disp), (m_mode == M_EXEC)}) begin
                errors++;
                $display("FAIL rand_key%0d code=%0d: a=%h b=%h sub=%b disp=%h opv=%b, required %h %h %b %h %b",
                         i, code, bus1.a, bus1.b, bus1.sub, bus1.display, bus1.op_valid,
                         bcd8(m_a), bcd8(m_b), m_sub, bcd8(m_disp), (m_mode == M_EXEC));
            end
            if (m_mode == M_EXEC) begin
                exec_step(1'b1);
                checks++;
                if ({bus1.a, bus1.display, bus1.op_valid} !== {bcd8(m_a), bcd8(m_disp), 1'b0}) begin
                    errors++;
                    $display("FAIL rand_exec%0d: a=%h disp=%h opv=%b, required %h %h 0",
                             i, bus1.a, bus1.display, bus1.op_valid, bcd8(m_a), bcd8(m_disp));
                end
            end
        end
    endtask

    initial begin
        bus1.key_valid = 1'b0;
        bus1.key_code  = 4'd0;
        bus0.key_valid = 1'b0;
        bus0.key_code  = 4'd0;
        model_reset();
        test_reset();
        test_add();
        test_sub_wrap();
        test_overflow_clear();
        test_repeat_eq();
        test_pending_exec();
        test_reset_in_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d required completion", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
